// File: rtl/aes_inv_cipher_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : aes_pkg
// Purpose  : Shared types, constants and GF(2^8) helpers for the AES-128
//            inverse cipher controller and its round datapath.
// Revision : 1.0
// ============================================================================
package aes_pkg;

    typedef logic [127:0] aes_state_t;
    typedef logic [31:0]  aes_word_t;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ARK  = 3'd1,
        ISR  = 3'd2,
        ISB  = 3'd3,
        IMC  = 3'd4,
        DONE = 3'd5
    } inv_ctrl_state_e;

    localparam int AES128_NR = 10;

    // Bit offset of the top of column c (byte0 of the state is [127:120]).
    function automatic int col_slice(input int c);
        return 127 - 32 * c;
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        logic [7:0] bb;
        p  = 8'h00;
        x  = a;
        bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ x;
            x  = xtime(x);
            bb = bb >> 1;
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254 (bits 1..7 of 254 are set); 0 maps to 0.
    function automatic logic [7:0] ginv(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] sq;
        r  = 8'h01;
        sq = a;
        for (int i = 1; i < 8; i++) begin
            sq = gmul(sq, sq);
            r  = gmul(r, sq);
        end
        return r;
    endfunction

    // Inverse S-box: undo the affine map, then invert in GF(2^8).
    function automatic logic [7:0] inv_sbox(input logic [7:0] a);
        logic [7:0] b;
        b = {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05;
        return ginv(b);
    endfunction

    function automatic aes_word_t inv_mix_word(input aes_word_t w);
        logic [7:0] a0, a1, a2, a3;
        a0 = w[31:24];
        a1 = w[23:16];
        a2 = w[15:8];
        a3 = w[7:0];
        return {gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09),
                gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d),
                gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b),
                gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e)};
    endfunction

endpackage
`default_nettype wire

// File: rtl/aes_inv_cipher_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : aes_inv_cipher_ctrl_if
// Purpose  : Bundle of the controller's request, key-fetch and result signals.
//            master = wrapper / key store side, slave = controller.
// Revision : 1.0
// ============================================================================
interface aes_inv_cipher_ctrl_if;
    import aes_pkg::*;

    logic       start;
    aes_state_t msg_in;
    aes_state_t rk_in;
    logic [3:0] rk_idx;
    logic       busy;
    logic       done;
    aes_state_t msg_out;

    modport master (
        output start, msg_in, rk_in,
        input  rk_idx, busy, done, msg_out
    );

    modport slave (
        input  start, msg_in, rk_in,
        output rk_idx, busy, done, msg_out
    );
endinterface
`default_nettype wire

// File: rtl/aes_inv_cipher_ctrl_dp.sv
`default_nettype none
// ============================================================================
// Module   : aes_inv_round_dp
// Purpose  : Combinational inverse-round datapath: InvShiftRows, InvSubBytes,
//            AddRoundKey and single-column InvMixColumns, selected by the
//            controller's current step.
// Revision : 1.0
// ============================================================================
module aes_inv_round_dp
    import aes_pkg::*;
(
    input  inv_ctrl_state_e fsm_state,
    input  logic [1:0]      col,
    input  aes_state_t      state,
    input  aes_state_t      round_key,
    output aes_state_t      next_state
);
    aes_state_t isr_state;
    aes_state_t isb_state;
    aes_state_t imc_state;

    // Byte k sits at row k%4, column k/4; row r rotates right by r columns.
    for (genvar k = 0; k < 16; k++) begin : g_byte
        localparam int BYTE_ROW = k % 4;
        localparam int BYTE_COL = k / 4;
        localparam int SRC      = 4 * ((BYTE_COL - BYTE_ROW + 4) % 4) + BYTE_ROW;
        assign isr_state[127-8*k -: 8] = state[127-8*SRC -: 8];
        assign isb_state[127-8*k -: 8] = inv_sbox(state[127-8*k -: 8]);
    end

    // One shared-width mixer per column slot; only the selected column changes.
    for (genvar c = 0; c < 4; c++) begin : g_col
        localparam int HI = col_slice(c);
        assign imc_state[HI -: 32] = (col == 2'(c)) ? inv_mix_word(state[HI -: 32])
                                                    : state[HI -: 32];
    end

    // Select the transform for the current controller step.
    always_comb begin
        next_state = state;
        case (fsm_state)
            ARK:     next_state = state ^ round_key;
            ISR:     next_state = isr_state;
            ISB:     next_state = isb_state;
            IMC:     next_state = imc_state;
            default: next_state = state;
        endcase
    end
endmodule
`default_nettype wire

// File: rtl/aes_inv_cipher_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : aes_inv_cipher_ctrl
// Purpose  : AES-128 inverse cipher sequencer. One transform per clock over a
//            single 128-bit state register; round keys fetched by index.
// Revision : 1.0
// ============================================================================
module aes_inv_cipher_ctrl
    import aes_pkg::*;
#(
    parameter int NR = AES128_NR
)(
    input  logic                  CLK,
    input  logic                  RESET,
    aes_inv_cipher_ctrl_if.slave  bus
);
    localparam logic [3:0] NR_4 = 4'(NR);

    inv_ctrl_state_e st;
    inv_ctrl_state_e st_nxt;
    aes_state_t      state_reg;
    aes_state_t      dp_next;
    logic [3:0]      rnd;
    logic [1:0]      col;

    aes_inv_round_dp u_dp (
        .fsm_state  (st),
        .col        (col),
        .state      (state_reg),
        .round_key  (bus.rk_in),
        .next_state (dp_next)
    );

    // FSM state register.
    always_ff @(posedge CLK) begin
        if (RESET) st <= IDLE;
        else       st <= st_nxt;
    end

    // Next-state decode; start is only looked at in IDLE and DONE.
    always_comb begin
        st_nxt = st;
        case (st)
            IDLE: if (bus.start) st_nxt = ARK;
            ARK: begin
                if (rnd == 4'd0)      st_nxt = DONE;
                else if (rnd == NR_4) st_nxt = ISR;
                else                  st_nxt = IMC;
            end
            ISR:  st_nxt = ISB;
            ISB:  st_nxt = ARK;
            IMC:  if (col == 2'd3) st_nxt = ISR;
            DONE: if (!bus.start) st_nxt = IDLE;
            default: st_nxt = IDLE;
        endcase
    end

    // Status flags decoded from the current state.
    always_comb begin
        bus.busy = (st != IDLE) && (st != DONE);
        bus.done = (st == DONE);
    end

    // State register and round/column counters; rnd stops at 0 on the final ARK.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_reg <= '0;
            rnd       <= '0;
            col       <= '0;
        end else begin
            case (st)
                IDLE: begin
                    if (bus.start) begin
                        state_reg <= bus.msg_in;
                        rnd       <= NR_4;
                        col       <= '0;
                    end
                end
                ARK: begin
                    state_reg <= dp_next;
                    if (rnd != 4'd0) rnd <= rnd - 4'd1;
                end
                ISR, ISB: state_reg <= dp_next;
                IMC: begin
                    state_reg <= dp_next;
                    col       <= col + 2'd1;
                end
                default: ;
            endcase
        end
    end

    assign bus.rk_idx  = rnd;
    assign bus.msg_out = state_reg;
endmodule
`default_nettype wire

// File: tb/tb_aes_inv_cipher_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_aes_inv_cipher_ctrl
// Purpose  : Directed self-checking bench for aes_inv_cipher_ctrl using the
//            FIPS-197 known-answer vectors and a key-schedule model.
// Revision : 1.0
// ============================================================================
module tb_aes_inv_cipher_ctrl;
    import aes_pkg::*;

    localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;

    logic CLK;
    logic RESET;
    int   checks;
    int   passed;
    logic [127:0] rk_tab [16];

    aes_inv_cipher_ctrl_if bus ();

    aes_inv_cipher_ctrl #(.NR(10)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    // Key-schedule store: same-cycle lookup by requested index.
    always_comb bus.rk_in = rk_tab[bus.rk_idx];

    function automatic logic [7:0] tb_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        logic [7:0] bb;
        p = 8'h00; x = a; bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ x;
            x  = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            bb = bb >> 1;
        end
        return p;
    endfunction

    // Forward S-box: brute-force inverse, then the forward affine map.
    function automatic logic [7:0] tb_sbox(input logic [7:0] x);
        logic [7:0] inv;
        logic [7:0] yb;
        inv = 8'h00;
        for (int y = 1; y < 256; y++) begin
            yb = y[7:0];
            if (tb_mul(x, yb) == 8'h01) inv = yb;
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
               {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    task automatic expand_key(input logic [127:0] key);
        logic [31:0]  w [44];
        logic [31:0]  t;
        logic [7:0]   rc;
        logic [127:0] tmp;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) begin
            tmp  = key << (32 * i);
            w[i] = tmp[127:96];
        end
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t  = {t[23:0], t[31:24]};
                t  = {tb_sbox(t[31:24]), tb_sbox(t[23:16]), tb_sbox(t[15:8]), tb_sbox(t[7:0])}
                     ^ {rc, 24'h0};
                rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 16; r++) begin
            if (r <= 10) rk_tab[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
            else         rk_tab[r] = '0;
        end
    endtask

    // Present a request and pass the sampling edge; afterwards cycle 0 is visible.
    task automatic launch(input logic [127:0] ct);
        bus.msg_in = ct;
        bus.start  = 1'b1;
        @(posedge CLK); #1;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!bus.done && n < 200) begin
            @(posedge CLK); #1;
            n++;
        end
    endtask

    task automatic finish_op();
        bus.start = 1'b0;
        @(posedge CLK); #1;
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        bus.start = 1'b0;
        bus.msg_in = '0;
        repeat (3) @(posedge CLK);
        #1;
        checks++; if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %0b want 0", bus.busy); else passed++;
        checks++; if (bus.done !== 1'b0) $display("FAIL reset_done: got %0b want 0", bus.done); else passed++;
        checks++; if (bus.msg_out !== 128'h0) $display("FAIL reset_msg_out: got %h want 0", bus.msg_out); else passed++;
        checks++; if (bus.rk_idx !== 4'd0) $display("FAIL reset_rk_idx: got %0d want 0", bus.rk_idx); else passed++;
        RESET = 1'b0;
        @(posedge CLK); #1;
        checks++; if (bus.busy !== 1'b0) $display("FAIL idle_no_start_busy: got %0b want 0", bus.busy); else passed++;
    endtask

    task automatic test_fips_b();
        int n;
        expand_key(KEY_B);
        launch(CT_B);
        bus.start = 1'b0;
        checks++; if (bus.busy !== 1'b1) $display("FAIL b_busy: got %0b want 1", bus.busy); else passed++;
        wait_done(n);
        checks++; if (n !== 67) $display("FAIL b_latency: got %0d want 67", n); else passed++;
        checks++; if (bus.msg_out !== PT_B) $display("FAIL b_plaintext: got %h want %h", bus.msg_out, PT_B); else passed++;
        checks++; if (bus.busy !== 1'b0) $display("FAIL b_busy_at_done: got %0b want 0", bus.busy); else passed++;
        finish_op();
        checks++; if (bus.done !== 1'b0) $display("FAIL b_back_to_idle: done got %0b want 0", bus.done); else passed++;
    endtask

    task automatic test_fips_c_trace();
        logic [3:0] trace [$];
        int n;
        expand_key(KEY_C);
        launch(CT_C);
        bus.start = 1'b0;
        n = 0;
        while (!bus.done && n < 200) begin
            if (dut.st == ARK) trace.push_back(bus.rk_idx);
            @(posedge CLK); #1;
            n++;
        end
        checks++; if (n !== 67) $display("FAIL c_latency: got %0d want 67", n); else passed++;
        checks++; if (bus.msg_out !== PT_C) $display("FAIL c_plaintext: got %h want %h", bus.msg_out, PT_C); else passed++;
        checks++; if (trace.size() !== 11) $display("FAIL c_ark_count: got %0d want 11", trace.size()); else passed++;
        for (int i = 0; i < 11; i++) begin
            checks++;
            if (i >= trace.size()) $display("FAIL c_rk_trace[%0d]: got none want %0d", i, 10 - i);
            else if (trace[i] !== 4'(10 - i)) $display("FAIL c_rk_trace[%0d]: got %0d want %0d", i, trace[i], 10 - i);
            else passed++;
        end
        finish_op();
    endtask

    task automatic test_hold_start();
        int n;
        int drops;
        expand_key(KEY_B);
        launch(CT_B);
        wait_done(n);
        checks++; if (n !== 67) $display("FAIL hold_latency: got %0d want 67", n); else passed++;
        drops = 0;
        repeat (200 - 67) begin
            @(posedge CLK); #1;
            if (bus.done !== 1'b1 || bus.busy !== 1'b0) drops++;
        end
        checks++; if (drops !== 0) $display("FAIL hold_done_stays: got %0d bad cycles want 0", drops); else passed++;
        checks++; if (bus.msg_out !== PT_B) $display("FAIL hold_result: got %h want %h", bus.msg_out, PT_B); else passed++;
        bus.start = 1'b0;
        @(posedge CLK); #1;
        checks++; if ({bus.busy, bus.done} !== 2'b00) $display("FAIL hold_idle_visit: got busy/done %b want 00", {bus.busy, bus.done}); else passed++;
        launch(CT_B);
        bus.start = 1'b0;
        checks++; if (bus.busy !== 1'b1) $display("FAIL hold_restart_busy: got %0b want 1", bus.busy); else passed++;
        wait_done(n);
        checks++; if (n !== 67) $display("FAIL hold_second_latency: got %0d want 67", n); else passed++;
        checks++; if (bus.msg_out !== PT_B) $display("FAIL hold_second_result: got %h want %h", bus.msg_out, PT_B); else passed++;
        finish_op();
    endtask

    task automatic test_reset_mid_op();
        int n;
        expand_key(KEY_B);
        launch(CT_B);
        bus.start = 1'b0;
        repeat (30) @(posedge CLK);
        #1;
        checks++; if (bus.busy !== 1'b1) $display("FAIL mid_busy_before_reset: got %0b want 1", bus.busy); else passed++;
        RESET = 1'b1;
        @(posedge CLK); #1;
        RESET = 1'b0;
        checks++; if (bus.busy !== 1'b0) $display("FAIL mid_reset_busy: got %0b want 0", bus.busy); else passed++;
        checks++; if (bus.done !== 1'b0) $display("FAIL mid_reset_done: got %0b want 0", bus.done); else passed++;
        checks++; if (bus.msg_out !== 128'h0) $display("FAIL mid_reset_msg_out: got %h want 0", bus.msg_out); else passed++;
        checks++; if (bus.rk_idx !== 4'd0) $display("FAIL mid_reset_rk_idx: got %0d want 0", bus.rk_idx); else passed++;
        expand_key(KEY_C);
        launch(CT_C);
        bus.start = 1'b0;
        wait_done(n);
        checks++; if (n !== 67) $display("FAIL mid_after_latency: got %0d want 67", n); else passed++;
        checks++; if (bus.msg_out !== PT_C) $display("FAIL mid_after_result: got %h want %h", bus.msg_out, PT_C); else passed++;
        finish_op();
    endtask

    task automatic test_msg_in_change();
        int n;
        expand_key(KEY_B);
        launch(CT_B);
        bus.start  = 1'b0;
        bus.msg_in = '1;
        wait_done(n);
        checks++; if (n !== 67) $display("FAIL msgchg_latency: got %0d want 67", n); else passed++;
        checks++; if (bus.msg_out !== PT_B) $display("FAIL msgchg_result: got %h want %h", bus.msg_out, PT_B); else passed++;
        bus.msg_in = '0;
        finish_op();
    endtask

    task automatic test_reset_with_start();
        int n;
        int bad;
        expand_key(KEY_C);
        RESET      = 1'b1;
        bus.msg_in = CT_C;
        bus.start  = 1'b1;
        bad = 0;
        repeat (3) begin
            @(posedge CLK); #1;
            if (bus.busy !== 1'b0 || bus.done !== 1'b0) bad++;
        end
        checks++; if (bad !== 0) $display("FAIL rst_start_held_idle: got %0d active cycles want 0", bad); else passed++;
        RESET = 1'b0;
        @(posedge CLK); #1;
        checks++; if (bus.busy !== 1'b1) $display("FAIL rst_start_first_edge: busy got %0b want 1", bus.busy); else passed++;
        bus.start = 1'b0;
        wait_done(n);
        checks++; if (n !== 67) $display("FAIL rst_start_latency: got %0d want 67", n); else passed++;
        checks++; if (bus.msg_out !== PT_C) $display("FAIL rst_start_result: got %h want %h", bus.msg_out, PT_C); else passed++;
        finish_op();
    endtask

    initial begin
        CLK    = 1'b0;
        RESET  = 1'b1;
        checks = 0;
        passed = 0;
        for (int r = 0; r < 16; r++) rk_tab[r] = '0;
        test_reset();
        test_fips_b();
        test_fips_c_trace();
        test_hold_start();
        test_reset_mid_op();
        test_msg_in_change();
        test_reset_with_start();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/aes_inv_cipher_ctrl.md
Name: aes_inv_cipher_ctrl

Overview:
Sequences the AES-128 inverse cipher over one 128-bit state register, applying one transformation per clock. Transformations are inverse-ShiftRows, inverse-SubBytes, AddRoundKey and a 32-bit-wide InvMixColumns that is reused once per column. It fetches round keys by index from the external key-schedule store. It sits between the bus-facing AES wrapper (start/done/message registers) and the combinational inverse-round datapath blocks.

Parameters:
NR, 10, number of AES rounds (AES-128 only; other values unsupported)

Ports:
CLK  in  1  system clock, all logic on rising edge
RESET  in  1  synchronous, active-high reset
start  in  1  level request; sampled only in IDLE
msg_in  in  128  ciphertext; byte0 = [127:120], column c = [127-32c -: 32]
rk_in  in  128  round key for rk_idx, combinational same-cycle return
rk_idx  out  4  round-key index requested this cycle (0..10)
busy  out  1  high in every state except IDLE and DONE
done  out  1  high while in DONE
msg_out  out  128  state register; plaintext valid while done=1

Behaviour:
- One clock (CLK). Reset is synchronous and active-high (RESET).
- Reset values: FSM=IDLE, state reg=0, rnd=0, col=0, done=0, busy=0, rk_idx=0.
- RESET asserted mid-operation aborts the operation. The next cycle is IDLE with all registers cleared; no partial result is flagged.
- FSM states: IDLE, ARK, ISR, ISB, IMC, DONE.
- IDLE: if start=1 at the edge, load state<=msg_in, rnd<=NR, col<=0, and go to ARK. Otherwise stay in IDLE.
- ARK: rk_idx=rnd. At the edge, state<=state^rk_in. Then:
  - rnd==0 -> DONE.
  - rnd==NR -> ISR.
  - Otherwise -> IMC.
  - rnd decrements at the edge in every case except the rnd==0 exit.
- IMC: replaces column col with InvMixColumns(column col); the other columns are held. col increments each edge. col==3 -> ISR and col wraps to 0.
- ISR: state<=InvShiftRows(state) -> ISB.
- ISB: state<=InvSubBytes(state) (all 16 bytes, combinational S-box) -> ARK.
- Operation order is therefore: ARK(10); then for r=9..1: ISR, ISB, ARK(r), IMC×4; then ISR, ISB, ARK(0).
- Latency: exactly 67 transform edges. done rises 67 clocks after the edge that sampled start=1 in IDLE.
- rk_idx is driven =rnd in every state. Only its value in ARK is meaningful.
- DONE: done=1, msg_out stable. Return to IDLE on the first edge where start=0.
  - start held high keeps the block in DONE; it does not retrigger.
  - A new operation requires start to be deasserted, then reasserted.
- start changes while busy=1 are ignored. msg_in is sampled only on the IDLE->ARK edge, so later changes have no effect.
- rnd is 4 bits and never underflows; the ARK exit is taken at rnd==0.

Decomposition:
- Shared package aes_pkg:
  - typedef aes_state_t = logic[127:0];
  - typedef aes_word_t = logic[31:0];
  - enum inv_ctrl_state_e {IDLE, ARK, ISR, ISB, IMC, DONE};
  - constant AES128_NR = 10;
  - function col_slice(c), returning the bit offset 127-32c.
- One sub-module, aes_inv_round_dp (purely combinational):
  - Instantiates the existing inverse-ShiftRows, inverse-SubBytes and word InvMixColumns blocks.
  - Muxes the next-state value by the current FSM state and col.
  - The controller keeps the FSM, counters and state register.

Test Plan:
1. FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c, ct 3925841d02dc09fbdc118597196a0b32. The bench key-schedule model serves rk_in. Required: msg_out=3243f6a8885a308d313198a2e0370734 and done rising exactly 67 clocks after the start-sampling edge.
2. FIPS-197 App. C.1: key 000102…0f, ct 69c4e0d86a7b0430d8cdb78070b4c55a -> pt 00112233445566778899aabbccddeeff. Also check the rk_idx trace 10, 9, …, 0, with each value asserted only in ARK cycles in that order.
3. Hold start=1 for 200 clocks: one result only, done stays 1. Drop start, then reassert with vector 1: second result correct, and IDLE is visited for exactly 1 cycle.
4. Pulse RESET at clock 30 of an operation: next cycle busy=0, done=0, msg_out=0. A following start with vector 2 completes correctly in 67 clocks.
5. Change msg_in to all-ones at clocks 1..66 of an operation: result is still the vector-1 plaintext.
6. Assert RESET and start together: the block stays in IDLE. start is honoured only on the first edge after RESET deasserts.
